// File: rtl/m68k_ram_arbiter.sv
// ---------------------------------------------------------------------------
// m68k_ram_arbiter
//   Round-robin arbiter sharing one registered 16-bit byte-lane RAM
//   (one-cycle read latency) among NREQ requesters. Each access runs as a
//   three-state transaction (IDLE -> ISSUE -> WAIT). Byte-lane writes are
//   steered to the RAM. Read data comes back with a one-cycle ack pulse.
//
// Configuration macro:
//   M68K_RAM_ARB_PRIO0_EN - when defined, requester 0 wins whenever it is
//                           eligible in IDLE. Requesters 1..NREQ-1
//                           round-robin among themselves.
//
// Ports:
//   clock_i        system clock, all logic on posedge
//   reset_i        asynchronous active-high reset
//   req_i          per-requester level request, held until ack
//   we_i           per-requester write (1) / read (0)
//   be_i           byte enables, requester i uses [2i+1:2i] ([1] = high byte)
//   addr_i         word address, requester i uses slice i
//   wdata_i        write data, requester i uses slice i
//   ack_o          one-cycle completion pulse (one-hot or zero)
//   rdata_o        read data of the last completed access
//   ram_address_o  RAM word address
//   ram_data_o     RAM write data
//   ram_we_l_o     RAM low-byte write enable
//   ram_we_h_o     RAM high-byte write enable
//   ram_q_i        registered RAM read data
//   busy_o         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module m68k_ram_arbiter #(
    parameter int NREQ    = 3,
    parameter int WIDTHAD = 10
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         we_i,
    input  logic [2*NREQ-1:0]       be_i,
    input  logic [NREQ*WIDTHAD-1:0] addr_i,
    input  logic [16*NREQ-1:0]      wdata_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [15:0]             rdata_o,
    output logic [WIDTHAD-1:0]      ram_address_o,
    output logic [15:0]             ram_data_o,
    output logic                    ram_we_l_o,
    output logic                    ram_we_h_o,
    input  logic [15:0]             ram_q_i,
    output logic                    busy_o
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        winner_q, winner_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [WIDTHAD-1:0]   ram_address_q, ram_address_d;
    logic [15:0]          ram_data_q, ram_data_d;
    logic                 ram_we_l_q, ram_we_l_d;
    logic                 ram_we_h_q, ram_we_h_d;
    logic                 busy_q, busy_d;

    logic [NREQ-1:0]      eligible_s;
    logic                 found_s;
    logic [GW-1:0]        pick_s;
    logic [WIDTHAD-1:0]   addr_arr_s  [NREQ];
    logic [15:0]          wdata_arr_s [NREQ];
    logic [1:0]           be_arr_s    [NREQ];

    // A requester acked in this very cycle is excluded so its still-high
    // request cannot be granted a second time.
    assign eligible_s = req_i & ~ack_q;

    // Unpack the flat per-requester buses into arrays indexed by requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr_s[i]  = addr_i[i*WIDTHAD +: WIDTHAD];
            wdata_arr_s[i] = wdata_i[i*16 +: 16];
            be_arr_s[i]    = be_i[i*2 +: 2];
        end
    end

    // Winner selection: first eligible requester after last_grant, wrapping.
    always_comb begin
        logic [GW-1:0] idx_v;
        logic          hit_v;
        found_s = 1'b0;
        pick_s  = '0;
        idx_v   = '0;
        hit_v   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v = GW'((int'(last_grant_q) + k) % NREQ);
`ifdef M68K_RAM_ARB_PRIO0_EN
            hit_v = eligible_s[idx_v] && !found_s && (idx_v != '0);
`else
            hit_v = eligible_s[idx_v] && !found_s;
`endif
            pick_s  = hit_v ? idx_v : pick_s;
            found_s = found_s | hit_v;
        end
`ifdef M68K_RAM_ARB_PRIO0_EN
        // Requester 0 overrides the rotation whenever it is eligible.
        pick_s  = eligible_s[0] ? '0 : pick_s;
        found_s = found_s | eligible_s[0];
`endif
    end

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        last_grant_d  = last_grant_q;
        ack_d         = '0;
        rdata_d       = rdata_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_we_l_d    = ram_we_l_q;
        ram_we_h_d    = ram_we_h_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    winner_d      = pick_s;
                    ram_address_d = addr_arr_s[pick_s];
                    ram_data_d    = wdata_arr_s[pick_s];
                    ram_we_l_d    = we_i[pick_s] & be_arr_s[pick_s][0];
                    ram_we_h_d    = we_i[pick_s] & be_arr_s[pick_s][1];
                    state_d       = S_ISSUE;
                end else begin
                    state_d       = S_IDLE;
                end
            end
            S_ISSUE: begin
                // RAM samples address/data/enables on this edge.
                ram_we_l_d = 1'b0;
                ram_we_h_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                rdata_d         = ram_q_i;
                // A requester that dropped its request gets no ack.
                ack_d[winner_q] = req_i[winner_q];
`ifdef M68K_RAM_ARB_PRIO0_EN
                // Rotation pointer tracks only the round-robin group.
                last_grant_d    = (winner_q != '0) ? winner_q : last_grant_q;
`else
                last_grant_d    = winner_q;
`endif
                state_d         = S_IDLE;
            end
            default: begin
                ram_we_l_d = 1'b0;
                ram_we_h_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            winner_q      <= '0;
            last_grant_q  <= GW'(NREQ - 1);
            ack_q         <= '0;
            rdata_q       <= 16'h0000;
            ram_address_q <= '0;
            ram_data_q    <= 16'h0000;
            ram_we_l_q    <= 1'b0;
            ram_we_h_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_grant_q  <= last_grant_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_we_l_q    <= ram_we_l_d;
            ram_we_h_q    <= ram_we_h_d;
            busy_q        <= busy_d;
        end
    end

    assign ack_o         = ack_q;
    assign rdata_o       = rdata_q;
    assign ram_address_o = ram_address_q;
    assign ram_data_o    = ram_data_q;
    assign ram_we_l_o    = ram_we_l_q;
    assign ram_we_h_o    = ram_we_h_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_m68k_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_m68k_ram_arbiter
//   Directed bench for m68k_ram_arbiter (NREQ=3, WIDTHAD=10) with a
//   registered write-through RAM model attached to the RAM port.
// ---------------------------------------------------------------------------
module tb_m68k_ram_arbiter;

    localparam int NREQ = 3;
    localparam int WA   = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req = 3'b000;
    logic [2:0]      we = 3'b000;
    logic [5:0]      be = 6'b000000;
    logic [29:0]     addr = 30'h0;
    logic [47:0]     wdata = 48'h0;
    logic [2:0]      ack;
    logic [15:0]     rdata;
    logic [9:0]      ram_address;
    logic [15:0]     ram_data;
    logic            ram_we_l;
    logic            ram_we_h;
    logic [15:0]     ram_q;
    logic            busy;

    logic            preload = 1'b1;
    logic [15:0]     mem [0:1023];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [2:0]  ord   [4];
    int          ordi  [4];
    logic [15:0] rd    [3];
    logic [2:0]  exp_ack;

    always #5 clk = ~clk;

    m68k_ram_arbiter #(.NREQ(NREQ), .WIDTHAD(WA)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .req_i         (req),
        .we_i          (we),
        .be_i          (be),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .ack_o         (ack),
        .rdata_o       (rdata),
        .ram_address_o (ram_address),
        .ram_data_o    (ram_data),
        .ram_we_l_o    (ram_we_l),
        .ram_we_h_o    (ram_we_h),
        .ram_q_i       (ram_q),
        .busy_o        (busy)
    );

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic wl, input logic wh);
        logic [15:0] r;
        r = old;
        if (wl) r[7:0]  = d[7:0];
        if (wh) r[15:8] = d[15:8];
        return r;
    endfunction

    // Registered single-port RAM with write-through read data.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[5] <= 16'hBEEF;
            ram_q  <= 16'h0000;
        end else begin
            mem[ram_address] <= merge(mem[ram_address], ram_data, ram_we_l, ram_we_h);
            ram_q            <= merge(mem[ram_address], ram_data, ram_we_l, ram_we_h);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [1:0] b,
                           input logic [9:0] a, input logic [15:0] d);
        we[i]           = w;
        be[2*i +: 2]    = b;
        addr[10*i +: 10] = a;
        wdata[16*i +: 16] = d;
    endtask

    task automatic contend(input bit reraise0);
        for (int c = 0; c < 12; c++) begin
            tick();
            exp_ack = ((c % 3) == 2) ? ord[c/3] : 3'b000;
            chk("contend_ack", {29'd0, ack}, {29'd0, exp_ack});
            if ((c % 3) == 2) chk("contend_rdata", {16'd0, rdata}, {16'd0, rd[ordi[c/3]]});
            if (reraise0) req[0] = ~exp_ack[0];
        end
        req = 3'b000;
        tick();
        tick();
        chk("contend_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rd[0] = 16'hBEEF;
        rd[1] = 16'h1200;
        rd[2] = 16'h5555;

        // Reset state
        tick();
        tick();
        chk("rst_ack",   {29'd0, ack}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_addr",  {22'd0, ram_address}, 32'd0);
        chk("rst_data",  {16'd0, ram_data}, 32'd0);
        chk("rst_we",    {30'd0, ram_we_h, ram_we_l}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        preload = 1'b0;
        rst     = 1'b0;

        // 1: single read of word 0x005
        set_req(0, 1'b0, 2'b00, 10'h005, 16'h0000);
        req = 3'b001;
        tick();
        chk("rd_busy", {31'd0, busy}, 32'd1);
        chk("rd_ack0", {29'd0, ack}, 32'd0);
        tick();
        chk("rd_addr", {22'd0, ram_address}, 32'h005);
        chk("rd_ack1", {29'd0, ack}, 32'd0);
        tick();
        chk("rd_ack2", {29'd0, ack}, 32'h1);
        chk("rd_data", {16'd0, rdata}, 32'hBEEF);
        req = 3'b000;
        tick();
        chk("rd_ackclr", {29'd0, ack}, 32'd0);
        chk("rd_idle",   {31'd0, busy}, 32'd0);

        // 2: high-byte write by requester 1, then read back
        set_req(1, 1'b1, 2'b10, 10'h03C, 16'h12AB);
        req = 3'b010;
        tick();
        chk("bw_we",   {30'd0, ram_we_h, ram_we_l}, 32'h2);
        chk("bw_data", {16'd0, ram_data}, 32'h12AB);
        chk("bw_addr", {22'd0, ram_address}, 32'h03C);
        tick();
        chk("bw_weclr", {30'd0, ram_we_h, ram_we_l}, 32'd0);
        tick();
        chk("bw_ack",   {29'd0, ack}, 32'h2);
        chk("bw_rdata", {16'd0, rdata}, 32'h1200);
        req = 3'b000;
        tick();
        set_req(1, 1'b0, 2'b00, 10'h03C, 16'h0000);
        req = 3'b010;
        tick();
        tick();
        tick();
        chk("bw_rb_ack",  {29'd0, ack}, 32'h2);
        chk("bw_rb_data", {16'd0, rdata}, 32'h1200);
        req = 3'b000;
        tick();

        // Write with be=00: no lanes written, ack still issued
        set_req(0, 1'b1, 2'b00, 10'h005, 16'hFFFF);
        req = 3'b001;
        tick();
        chk("be0_we", {30'd0, ram_we_h, ram_we_l}, 32'd0);
        tick();
        tick();
        chk("be0_ack",   {29'd0, ack}, 32'h1);
        chk("be0_rdata", {16'd0, rdata}, 32'hBEEF);
        req = 3'b000;
        tick();

        // 4: requester 2 writes then drops req before ack
        set_req(2, 1'b1, 2'b11, 10'h020, 16'h5555);
        req = 3'b100;
        tick();
        chk("drop_we", {30'd0, ram_we_h, ram_we_l}, 32'h3);
        req = 3'b000;
        tick();
        tick();
        chk("drop_noack", {29'd0, ack}, 32'd0);
        tick();
        chk("drop_idle", {31'd0, busy}, 32'd0);
        set_req(2, 1'b0, 2'b00, 10'h020, 16'h0000);
        req = 3'b100;
        tick();
        tick();
        tick();
        chk("drop_rb_ack",  {29'd0, ack}, 32'h4);
        chk("drop_rb_data", {16'd0, rdata}, 32'h5555);
        req = 3'b000;
        tick();

        // 5: reset while in WAIT
        set_req(0, 1'b0, 2'b00, 10'h005, 16'h0000);
        req = 3'b001;
        tick();
        tick();
        chk("rstw_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_ack",  {29'd0, ack}, 32'd0);
        req = 3'b000;
        tick();
        chk("rstw_noack", {29'd0, ack}, 32'd0);
        rst = 1'b0;

        // 3: held contention from reset, requester 0 first
        set_req(0, 1'b0, 2'b00, 10'h005, 16'h0000);
        set_req(1, 1'b0, 2'b00, 10'h03C, 16'h0000);
        set_req(2, 1'b0, 2'b00, 10'h020, 16'h0000);
        ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001;
        ordi[0] = 0;     ordi[1] = 1;     ordi[2] = 2;     ordi[3] = 0;
        req = 3'b111;
        contend(1'b0);

        // 6: contention with requester 0 re-raising after each ack
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef M68K_RAM_ARB_PRIO0_EN
        ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b001; ord[3] = 3'b100;
        ordi[0] = 0;     ordi[1] = 1;     ordi[2] = 0;     ordi[3] = 2;
`else
        ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001;
        ordi[0] = 0;     ordi[1] = 1;     ordi[2] = 2;     ordi[3] = 0;
`endif
        req = 3'b111;
        contend(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
